pipe_share_arbiter: RTL

Round-robin arbiter and sequencer that shares one fixed-latency, non-stallable 64-bit pipelined datapath between two requesters. The datapath is a LATENCY-stage register delay line, for example clock_delay with SIZE = LATENCY. The arbiter issues at most one operand per cycle into the datapath. It tracks each operand's owner in a parallel tag pipeline and routes each result back to the requester that issued it, exactly LATENCY cycles later. It sits between the two requesting units and the datapath; the datapath itself is untouched.

---
 rtl/pipe_share_arbiter_pkg.sv | 14 +
 rtl/pipe_tag_delay.sv | 33 +++
 rtl/pipe_share_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/pipe_share_arbiter_pkg.sv
// Shared definitions for the two-requester pipe sharing arbiter:
// requester identifiers and the tag that travels alongside each operand.
package pipe_share_arbiter_pkg;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One tag per datapath stage: whether the slot holds a live operation and who issued it
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/pipe_tag_delay.sv
// Tag shift register that runs in lockstep with the shared datapath.
// Its depth equals the datapath latency, so the last stage describes
// exactly the result currently leaving the datapath.
module pipe_tag_delay
  import pipe_share_arbiter_pkg::*;
#(
  parameter int LATENCY = 9
) (
  input  logic clock,
  input  logic reset,
  input  tag_t d,
  output tag_t q
);

  tag_t stages [LATENCY];

  // Shift tags one stage per cycle; reset forgets every in-flight operation
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= d;
      for (int i = 1; i < LATENCY; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[LATENCY-1];

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-stallable datapath
// between two requesters. Grants at most one operand per cycle, remembers
// the owner of each operand in a parallel tag pipeline and steers each
// result back to its owner when it leaves the datapath.
module pipe_share_arbiter
  import pipe_share_arbiter_pkg::*;
#(
  parameter int LATENCY = 9,
  parameter int WIDTH   = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pause,
  input  logic                         req0_valid,
  input  logic [WIDTH-1:0]             req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [WIDTH-1:0]             req1_data,
  output logic                         req1_ready,
  output logic                         pipe_in_valid,
  output logic [WIDTH-1:0]             pipe_in,
  input  logic [WIDTH-1:0]             pipe_out,
  output logic                         resp0_valid,
  output logic [WIDTH-1:0]             resp0_data,
  output logic                         resp1_valid,
  output logic [WIDTH-1:0]             resp1_data,
  output logic [$clog2(LATENCY+1)-1:0] in_flight,
  output logic                         idle
);

  localparam int CW = $clog2(LATENCY+1);

  logic prio;
  logic fire0;
  logic fire1;
  logic fire;
  logic retire;
  tag_t issue_tag;
  tag_t retire_tag;

  // Grant logic: a requester is ready when it holds priority or the other side is quiet.
  // Reset holds both grants low so nothing is issued while state is being cleared.
  always_comb begin
    req0_ready    = !reset && !pause && (prio == REQ0 || !req1_valid);
    req1_ready    = !reset && !pause && (prio == REQ1 || !req0_valid);
    fire0         = req0_valid && req0_ready;
    fire1         = req1_valid && req1_ready;
    fire          = fire0 || fire1;
    pipe_in_valid = fire;
    pipe_in       = fire1 ? req1_data : req0_data;
    issue_tag       = '0;
    issue_tag.valid = fire;
    issue_tag.owner = fire1 ? REQ1 : REQ0;
  end

  // Priority passes to the other requester after every grant, giving 0,1,0,1 under contention
  always_ff @(posedge clock) begin
    if (reset) begin
      prio <= REQ0;
    end else if (fire0) begin
      prio <= REQ1;
    end else if (fire1) begin
      prio <= REQ0;
    end
  end

  pipe_tag_delay #(
    .LATENCY (LATENCY)
  ) u_tags (
    .clock (clock),
    .reset (reset),
    .d     (issue_tag),
    .q     (retire_tag)
  );

  // Results are steered by the tag leaving the last stage; data goes straight through
  always_comb begin
    retire      = retire_tag.valid;
    resp0_valid = retire && retire_tag.owner == REQ0;
    resp1_valid = retire && retire_tag.owner == REQ1;
    resp0_data  = pipe_out;
    resp1_data  = pipe_out;
    idle        = in_flight == '0;
  end

  // Occupancy count: an issue and a retire in the same cycle cancel out
  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight <= '0;
    end else if (fire && !retire) begin
      in_flight <= in_flight + CW'(1);
    end else if (!fire && retire) begin
      in_flight <= in_flight - CW'(1);
    end
  end

endmodule
